// File: rtl/udb_sweep_ctrl_if.sv
// Sweep controller bundle: job request, bounds, counter feedback and status.
// The master side drives the job and the counter value; the slave is the controller.
interface udb_sweep_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             udb_sweep_ctrl_start;
    logic             udb_sweep_ctrl_abort;
    logic [WIDTH-1:0] udb_sweep_ctrl_lo;
    logic [WIDTH-1:0] udb_sweep_ctrl_hi;
    logic [WIDTH-1:0] udb_sweep_ctrl_passes;
    logic [WIDTH-1:0] udb_sweep_ctrl_count;
    logic             udb_sweep_ctrl_load;
    logic [WIDTH-1:0] udb_sweep_ctrl_load_value;
    logic             udb_sweep_ctrl_direction;
    logic             udb_sweep_ctrl_busy;
    logic             udb_sweep_ctrl_done;
    logic             udb_sweep_ctrl_err;
    logic [WIDTH-1:0] udb_sweep_ctrl_pass_cnt;

    modport master (
        output udb_sweep_ctrl_start,
        output udb_sweep_ctrl_abort,
        output udb_sweep_ctrl_lo,
        output udb_sweep_ctrl_hi,
        output udb_sweep_ctrl_passes,
        output udb_sweep_ctrl_count,
        input  udb_sweep_ctrl_load,
        input  udb_sweep_ctrl_load_value,
        input  udb_sweep_ctrl_direction,
        input  udb_sweep_ctrl_busy,
        input  udb_sweep_ctrl_done,
        input  udb_sweep_ctrl_err,
        input  udb_sweep_ctrl_pass_cnt
    );

    modport slave (
        input  udb_sweep_ctrl_start,
        input  udb_sweep_ctrl_abort,
        input  udb_sweep_ctrl_lo,
        input  udb_sweep_ctrl_hi,
        input  udb_sweep_ctrl_passes,
        input  udb_sweep_ctrl_count,
        output udb_sweep_ctrl_load,
        output udb_sweep_ctrl_load_value,
        output udb_sweep_ctrl_direction,
        output udb_sweep_ctrl_busy,
        output udb_sweep_ctrl_done,
        output udb_sweep_ctrl_err,
        output udb_sweep_ctrl_pass_cnt
    );
endinterface

// File: rtl/udb_sweep_ctrl.sv
// Up/down sweep controller: drives an external counter between lo and hi
// for a requested number of passes, parking it at lo when finished.
module udb_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input logic            udb_sweep_ctrl_clk,
    input logic            udb_sweep_ctrl_rst,
    udb_sweep_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_PARK = 3'd4;
    localparam logic [WIDTH:0] ONE = 1;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_passes;
    logic [WIDTH-1:0] r_pass_cnt;
    logic             r_err;
    logic             w_set_err;
    logic             w_inc;
    logic             w_start;
    logic             w_bad_req;
    logic             w_oor;
    logic             w_at_hi;
    logic             w_at_lo;
    logic             w_last;
    logic             w_load;

    assign w_start   = (r_state == S_IDLE) && bus.udb_sweep_ctrl_start;
    assign w_bad_req = (bus.udb_sweep_ctrl_lo >= bus.udb_sweep_ctrl_hi)
                    || (bus.udb_sweep_ctrl_passes == '0);
    assign w_oor     = (bus.udb_sweep_ctrl_count < r_lo)
                    || (bus.udb_sweep_ctrl_count > r_hi);
    assign w_at_hi   = bus.udb_sweep_ctrl_count == r_hi;
    assign w_at_lo   = bus.udb_sweep_ctrl_count == r_lo;
    // Pass that is finishing now is the last one requested.
    assign w_last    = ({1'b0, r_pass_cnt} + ONE) == {1'b0, r_passes};

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.udb_sweep_ctrl_start)
                    w_next = w_bad_req ? S_PARK : S_LOAD;
            end
            S_LOAD: begin
                w_next    = bus.udb_sweep_ctrl_abort ? S_PARK : S_UP;
                w_set_err = bus.udb_sweep_ctrl_abort;
            end
            S_UP: begin
                if (bus.udb_sweep_ctrl_abort || w_oor) begin
                    w_next    = S_PARK;
                    w_set_err = 1'b1;
                end else if (w_at_hi) begin
                    w_next = S_DOWN;
                end
            end
            S_DOWN: begin
                if (bus.udb_sweep_ctrl_abort || w_oor) begin
                    w_next    = S_PARK;
                    w_set_err = 1'b1;
                end else if (w_at_lo) begin
                    w_inc  = 1'b1;
                    w_next = w_last ? S_PARK : S_UP;
                end
            end
            S_PARK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge udb_sweep_ctrl_clk) begin
        if (!udb_sweep_ctrl_rst) begin
            r_state    <= S_IDLE;
            r_lo       <= '0;
            r_hi       <= '0;
            r_passes   <= '0;
            r_pass_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_lo       <= bus.udb_sweep_ctrl_lo;
                r_hi       <= bus.udb_sweep_ctrl_hi;
                r_passes   <= bus.udb_sweep_ctrl_passes;
                r_pass_cnt <= '0;
                r_err      <= w_bad_req;
            end else begin
                if (w_set_err)
                    r_err <= 1'b1;
                if (w_inc && !(&r_pass_cnt))
                    r_pass_cnt <= r_pass_cnt + 1'b1;
            end
        end
    end

    assign w_load = (r_state == S_LOAD) || (r_state == S_PARK);

    assign bus.udb_sweep_ctrl_load       = w_load;
    assign bus.udb_sweep_ctrl_load_value = w_load ? r_lo : '0;
    assign bus.udb_sweep_ctrl_busy       = r_state != S_IDLE;
    assign bus.udb_sweep_ctrl_done       = r_state == S_PARK;
    assign bus.udb_sweep_ctrl_err        = r_err;
    assign bus.udb_sweep_ctrl_pass_cnt   = r_pass_cnt;
    // Turning at lo only when another pass follows; otherwise keep heading down.
    assign bus.udb_sweep_ctrl_direction  =
        ((r_state == S_UP) && !w_at_hi) ||
        ((r_state == S_DOWN) && w_at_lo && !w_last);
endmodule

// File: tb/tb_udb_sweep_ctrl.sv
// Scoreboard bench for udb_sweep_ctrl: directed jobs push expected events,
// a negedge monitor pops and compares them against the DUT.
module tb_udb_sweep_ctrl;
    typedef struct {
        int         cyc;
        logic [3:0] lv;
        logic       err;
        logic [3:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic fin = 1'b0;
    logic cnt_chk_en = 1'b1;
    logic force_en = 1'b0;
    logic [3:0] force_val = 4'd0;
    logic [3:0] cnt = 4'd0;
    int   t;

    exp_t       done_q[$];
    exp_t       snap_q[$];
    logic [3:0] load_q[$];
    logic [3:0] cnt_q[$];
    exp_t       e;

    udb_sweep_ctrl_if #(.WIDTH(4)) sif ();

    udb_sweep_ctrl #(.WIDTH(4)) dut (
        .udb_sweep_ctrl_clk (clk),
        .udb_sweep_ctrl_rst (rst_n),
        .bus                (sif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External up/down counter; never reset by the controller.
    always @(posedge clk) begin
        if (sif.udb_sweep_ctrl_load)
            cnt <= sif.udb_sweep_ctrl_load_value;
        else if (sif.udb_sweep_ctrl_direction)
            cnt <= cnt + 4'd1;
        else
            cnt <= cnt - 4'd1;
    end
    assign sif.udb_sweep_ctrl_count = force_en ? force_val : cnt;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, got, want);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: no expected entry", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (fin) begin
            chk("done_left", done_q.size(), 0);
            chk("load_left", load_q.size(), 0);
            chk("cnt_left", cnt_q.size(), 0);
            chk("snap_left", snap_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else begin
            if (sif.udb_sweep_ctrl_done) begin
                if (done_q.size() == 0) begin
                    fail_evt("spurious_done");
                end else begin
                    e = done_q.pop_front();
                    chk("done_cyc", cyc, e.cyc);
                    chk("done_load", int'(sif.udb_sweep_ctrl_load), 1);
                    chk("done_lv", int'(sif.udb_sweep_ctrl_load_value), int'(e.lv));
                    chk("done_err", int'(sif.udb_sweep_ctrl_err), int'(e.err));
                    chk("done_pc", int'(sif.udb_sweep_ctrl_pass_cnt), int'(e.pc));
                end
            end else if (sif.udb_sweep_ctrl_load) begin
                if (load_q.size() == 0)
                    fail_evt("unexpected_load");
                else
                    chk("load_lv", int'(sif.udb_sweep_ctrl_load_value),
                        int'(load_q.pop_front()));
            end else if (sif.udb_sweep_ctrl_busy && cnt_chk_en) begin
                if (cnt_q.size() == 0)
                    fail_evt("extra_count");
                else
                    chk("count", int'(sif.udb_sweep_ctrl_count),
                        int'(cnt_q.pop_front()));
            end
            if (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
                e = snap_q.pop_front();
                chk("idle_cyc", cyc, e.cyc);
                chk("idle_busy", int'(sif.udb_sweep_ctrl_busy), 0);
                chk("idle_load", int'(sif.udb_sweep_ctrl_load), 0);
                chk("idle_lv", int'(sif.udb_sweep_ctrl_load_value), 0);
                chk("idle_dir", int'(sif.udb_sweep_ctrl_direction), 0);
                chk("idle_done", int'(sif.udb_sweep_ctrl_done), 0);
                chk("idle_err", int'(sif.udb_sweep_ctrl_err), int'(e.err));
                chk("idle_pc", int'(sif.udb_sweep_ctrl_pass_cnt), int'(e.pc));
            end
        end
    end

    task automatic push_done(input int c, input int lv, input int er, input int pc);
        exp_t x;
        x.cyc = c;
        x.lv  = 4'(lv);
        x.err = 1'(er);
        x.pc  = 4'(pc);
        done_q.push_back(x);
    endtask

    task automatic push_snap(input int c, input int er, input int pc);
        exp_t x;
        x.cyc = c;
        x.lv  = 4'd0;
        x.err = 1'(er);
        x.pc  = 4'(pc);
        snap_q.push_back(x);
    endtask

    task automatic push_cnts(input int vals[]);
        foreach (vals[i]) cnt_q.push_back(4'(vals[i]));
    endtask

    task automatic go(input int lo, input int hi, input int ps);
        sif.udb_sweep_ctrl_lo     = 4'(lo);
        sif.udb_sweep_ctrl_hi     = 4'(hi);
        sif.udb_sweep_ctrl_passes = 4'(ps);
        sif.udb_sweep_ctrl_start  = 1'b1;
        @(posedge clk); #1;
        sif.udb_sweep_ctrl_start  = 1'b0;
    endtask

    task automatic wait_idle(input int er, input int pc);
        for (int i = 0; i < 300; i++) begin
            if (!sif.udb_sweep_ctrl_busy) break;
            @(posedge clk); #1;
        end
        push_snap(cyc, er, pc);
        push_snap(cyc + 3, er, pc);
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        sif.udb_sweep_ctrl_start  = 1'b0;
        sif.udb_sweep_ctrl_abort  = 1'b0;
        sif.udb_sweep_ctrl_lo     = 4'd0;
        sif.udb_sweep_ctrl_hi     = 4'd0;
        sif.udb_sweep_ctrl_passes = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_snap(cyc, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Single pass 2..5..2
        t = cyc;
        load_q.push_back(4'd2);
        push_cnts('{2, 3, 4, 5, 4, 3, 2});
        push_done(t + 9, 2, 0, 1);
        go(2, 5, 1);
        wait_idle(0, 1);

        // Three full-range sweeps
        t = cyc;
        load_q.push_back(4'd0);
        for (int p = 0; p < 3; p++) begin
            for (int v = (p == 0) ? 0 : 1; v <= 15; v++) cnt_q.push_back(4'(v));
            for (int v = 14; v >= 0; v--) cnt_q.push_back(4'(v));
        end
        push_done(t + 93, 0, 0, 3);
        go(0, 15, 3);
        wait_idle(0, 3);

        // Degenerate requests go straight to PARK
        t = cyc;
        push_done(t + 1, 7, 1, 0);
        go(7, 7, 1);
        wait_idle(1, 0);
        t = cyc;
        push_done(t + 1, 2, 1, 0);
        go(2, 5, 0);
        wait_idle(1, 0);

        // Reset in IDLE clears the sticky error
        rst_n = 1'b0;
        push_snap(cyc + 1, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Abort in DOWN of pass 2 of 4
        t = cyc;
        load_q.push_back(4'd1);
        push_cnts('{1, 2, 3, 2, 1, 2, 3, 2});
        push_done(t + 10, 1, 1, 1);
        go(1, 3, 4);
        repeat (8) begin
            @(posedge clk); #1;
        end
        sif.udb_sweep_ctrl_abort = 1'b1;
        @(posedge clk); #1;
        sif.udb_sweep_ctrl_abort = 1'b0;
        wait_idle(1, 1);
        sif.udb_sweep_ctrl_abort = 1'b1;
        push_snap(cyc + 1, 1, 1);
        @(posedge clk); #1;
        sif.udb_sweep_ctrl_abort = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Counter forced out of range during UP
        t = cyc;
        load_q.push_back(4'd1);
        push_cnts('{1, 2, 9});
        push_done(t + 5, 1, 1, 0);
        go(1, 6, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        force_val = 4'd9;
        force_en  = 1'b1;
        @(posedge clk); #1;
        force_en  = 1'b0;
        wait_idle(1, 0);

        // Start while busy is ignored; bounds stay latched
        t = cyc;
        load_q.push_back(4'd2);
        push_cnts('{2, 3, 4, 5, 4, 3, 2});
        push_done(t + 9, 2, 0, 1);
        go(2, 5, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        sif.udb_sweep_ctrl_lo     = 4'd0;
        sif.udb_sweep_ctrl_hi     = 4'd15;
        sif.udb_sweep_ctrl_passes = 4'd3;
        sif.udb_sweep_ctrl_start  = 1'b1;
        @(posedge clk); #1;
        sif.udb_sweep_ctrl_start  = 1'b0;
        wait_idle(0, 1);

        // Reset mid-UP overrides start and abort, no done pulse
        cnt_chk_en = 1'b0;
        t = cyc;
        load_q.push_back(4'd2);
        go(2, 5, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sif.udb_sweep_ctrl_start = 1'b1;
        sif.udb_sweep_ctrl_abort = 1'b1;
        push_snap(cyc + 1, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sif.udb_sweep_ctrl_start = 1'b0;
        sif.udb_sweep_ctrl_abort = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // New job after reset, two passes
        cnt_chk_en = 1'b1;
        t = cyc;
        load_q.push_back(4'd2);
        push_cnts('{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2});
        push_done(t + 15, 2, 0, 2);
        go(2, 5, 2);
        wait_idle(0, 2);

        fin = 1'b1;
    end
endmodule

// File: doc/udb_sweep_ctrl.md
UDB_SWEEP_CTRL -- requirements
Module: udb_sweep_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, bit width of count, bounds, load value and pass fields.
REQ-002 SHALL have port: udb_sweep_ctrl_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: udb_sweep_ctrl_rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: udb_sweep_ctrl_start  in  1  request to begin a sweep job.
REQ-005 SHALL have port: udb_sweep_ctrl_abort  in  1  terminate the current job.
REQ-006 SHALL have ports: udb_sweep_ctrl_lo / _hi  in  WIDTH  lower / upper sweep bounds.
REQ-007 SHALL have port: udb_sweep_ctrl_passes  in  WIDTH  number of up-down passes requested.
REQ-008 SHALL have port: udb_sweep_ctrl_count  in  WIDTH  current value of the driven up/down counter.
REQ-009 SHALL have port: udb_sweep_ctrl_load  out  1  counter load strobe.
REQ-010 SHALL have port: udb_sweep_ctrl_load_value  out  WIDTH  counter load data.
REQ-011 SHALL have port: udb_sweep_ctrl_direction  out  1  counter direction, 1 = up, 0 = down.
REQ-012 SHALL have ports: udb_sweep_ctrl_busy / _done / _err  out  1  job active / one-cycle completion pulse / sticky error.
REQ-013 SHALL have port: udb_sweep_ctrl_pass_cnt  out  WIDTH  completed passes of the current or last job.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, UP, DOWN, PARK; busy = 1 in every state except IDLE.
REQ-015 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-016 On an accepted start, SHALL latch lo, hi and passes, clear pass_cnt and err, and go to LOAD.
REQ-017 On an accepted start with lo >= hi or passes == 0, SHALL set err and go to PARK, skipping LOAD, UP and DOWN.
REQ-018 LOAD SHALL last exactly 1 cycle with load = 1 and load_value = latched lo, then go to UP.
REQ-019 Counter model: it loads or steps by 1 on every edge, and count is observed 1 cycle after the controlling outputs.
REQ-020 direction SHALL be combinational: in UP, 1 unless count == hi; in DOWN, 0 unless count == lo and another pass remains; 0 in IDLE, LOAD and PARK.
REQ-021 In UP with count == hi, SHALL go to DOWN.
REQ-022 In DOWN with count == lo, SHALL increment pass_cnt.
REQ-023 After that increment, SHALL go to PARK if pass_cnt + 1 == passes, else to UP.
REQ-024 In UP or DOWN, count < lo or count > hi SHALL set err and go to PARK; this check has priority over REQ-021 to REQ-023.
REQ-025 abort = 1 in LOAD, UP or DOWN SHALL set err and go to PARK; abort SHALL have priority over every other transition.
REQ-026 abort = 1 in IDLE or PARK SHALL be ignored.
REQ-027 PARK SHALL last exactly 1 cycle with load = 1, load_value = latched lo and done = 1, then go to IDLE.
REQ-028 In IDLE, load SHALL be 0 and load_value SHALL be 0.
REQ-029 pass_cnt SHALL hold its final value in IDLE until the next accepted start.
REQ-030 pass_cnt SHALL saturate at 2^WIDTH-1 and never wrap.
REQ-031 err SHALL remain set until the next accepted start or reset.
REQ-032 All bound compares SHALL be unsigned WIDTH-bit compares; no arithmetic wider than WIDTH+1 bits.

Reset
REQ-033 On a rising edge with rst = 0: state = IDLE; load, load_value, direction, busy, done, err and pass_cnt = 0; latched lo, hi and passes = 0.
REQ-034 Reset SHALL be honoured in any state, including mid-sweep.
REQ-035 Reset SHALL override start and abort in the same cycle.
REQ-036 Reset SHALL NOT produce a done pulse.
REQ-037 The block SHALL NOT reset the external counter.

Verification
REQ-038 lo=2, hi=5, passes=1, start at cycle t -> load=1 at t+1 with load_value=2.
REQ-039 Same job -> count sequence 2,3,4,5,4,3,2, then done=1 with load=1 at t+9, then busy=0 and pass_cnt=1.
REQ-040 lo=0, hi=15, passes=3 -> three full 0..15..0 sweeps with no count outside 0..15; done once; pass_cnt=3; err=0.
REQ-041 lo=7, hi=7 (and separately passes=0) -> next cycle done=1, load_value=7, err=1, pass_cnt=0, no LOAD cycle.
REQ-042 abort asserted in DOWN of pass 2 of 4 -> next cycle PARK with done=1, err=1, pass_cnt=1.
REQ-043 Forced count=9 during UP with hi=6 -> err=1, PARK, done=1.
REQ-044 start re-asserted while busy -> ignored, with latched bounds unchanged.
REQ-045 rst=0 for 1 cycle mid-UP -> all outputs 0 the next cycle, no done pulse, and a new start is accepted afterwards.
